projectile_pool: RTL and testbench
==================================

// Module: projectile_pool
// PURPOSE
//  Multi-slot projectile engine replacing the single-bullet logic in game_top: N_SLOTS
//  bullets in flight, movement per tick, bounds kill, sequential bullet-vs-enemy scan.
//  Emits enemy kill pulses, a saturating score and a fire pulse for the SFX generator.
//  Sits between joystick/fire decode and the enemy manager / VGA renderer.
// PARAMETERS
//  N_SLOTS    4    bullet slots
//  N_ENEMIES  10   enemies checked per scan
//  COORD_W    10   coordinate width, unsigned
//  VEL_W      6    velocity width, signed two's complement
//  SCREEN_W   640  / SCREEN_H 480  playfield size
//  MARGIN     5    live region: x in [MARGIN, SCREEN_W-MARGIN], y in [MARGIN, SCREEN_H-MARGIN]
//  BULLET_W   5    / BULLET_H 10  bullet box; ENEMY_SZ 20 enemy square side
//  SCORE_MAX  99   score saturation value
//  LIFETIME   64   ticks before expiry (used only with PROJ_POOL_LIFETIME_EN)
// PORTS
//  clk           in   1                   clock
//  rst           in   1                   reset, asynchronous, active-high
//  tick          in   1                   1-cycle movement strobe
//  fire_valid    in   1                   fire request
//  fire_ready    out  1                   fire accepted when valid&ready
//  fire_x/y      in   COORD_W             spawn position
//  fire_dx/dy    in   VEL_W               signed velocity per tick
//  enemy_x/y     in   N_ENEMIES*COORD_W   enemy positions, flattened, idx e at [e*COORD_W +: COORD_W]
//  enemy_active  in   N_ENEMIES           enemy alive mask
//  slot_active   out  N_SLOTS             live bullets
//  slot_x/y      out  N_SLOTS*COORD_W     bullet positions, flattened like enemy_x
//  kill_valid    out  1                   1-cycle pulse: enemy kill_idx destroyed
//  kill_idx      out  $clog2(N_ENEMIES)   killed enemy index
//  score         out  8                   saturating hit count
//  fire_snd      out  1                   1-cycle pulse on each accepted fire
//  tick_overrun  out  1                   1-cycle pulse when a tick is dropped
// BEHAVIOUR
//  Reset (async): all slots inactive, positions 0, score 0, all pulses 0, FSM IDLE, pending 0.
//  FSM IDLE -> MOVE -> SCAN -> IDLE.
//  - IDLE: tick or pending -> MOVE (pending cleared). fire_ready = IDLE & any slot free.
//  - Fire: lowest free slot gets fire_x/y, dx/dy; fire_snd pulses same edge. dx=dy=0 is
//    consumed (ready honoured) but no slot allocated, no fire_snd.
//  - Fire+tick same IDLE cycle: both taken; new bullet moves in the following MOVE.
//  - MOVE (1 cycle, all slots parallel): if position inside live region, pos += sign-ext
//    velocity mod 2^COORD_W; else slot deactivated. Underflow wraps large, killed next MOVE.
//  - SCAN: pairs (s,e), s outer, e inner, one pair per cycle, N_SLOTS*N_ENEMIES cycles.
//    Hit if slot s active, enemy_active[e], e not in kill mask, and
//    bx+BULLET_W>=ex && bx<ex+ENEMY_SZ && by+BULLET_H>=ey && by<ey+ENEMY_SZ (COORD_W+1 bits).
//    On hit: kill_valid=1/kill_idx=e next cycle, slot s inactive, e set in kill mask,
//    score+1 saturating at SCORE_MAX, skip to slot s+1. Kill mask cleared on SCAN entry.
//  - tick outside IDLE: pending<=1; tick while pending already set -> tick_overrun pulse, dropped.
//  - enemy inputs sampled live each cycle; caller holds them stable for the scan.
//  - rst mid-scan: immediate abort, reset values; no partial kill pulse.
// CONFIGURATION
//  PROJ_POOL_LIFETIME_EN defined: per-slot tick counter set to LIFETIME on fire,
//    decremented each MOVE; slot deactivated in MOVE when counter is 0.
//  Undefined: no counter logic; slots end only by bounds or hit.
// TESTING
//  1 fire (100,100) dx=2 dy=-1, 3 ticks -> slot0 (106,97), fire_snd once, slot_active=0001.
//  2 4 fires, no tick -> slot_active=1111, fire_ready=0; 5th valid held until a slot frees.
//  3 slots 0,1 both overlap enemy 3 -> one kill_valid idx=3, score=1, slot0 dead, slot1 live.
//  4 bullet x=636 dx=1, tick -> deactivated at that MOVE, no kill; score 98 + 3 hits -> 99.
//  5 tick during SCAN, then 2nd tick -> pending MOVE after SCAN, 1 tick_overrun pulse.
//  6 rst asserted mid-SCAN -> all outputs reset values, fire_ready=1 after release.

Source files
------------

// File: rtl/projectile_pool.sv
// projectile_pool: N_SLOTS bullets in flight, per-tick movement, bounds kill,
// sequential bullet-vs-enemy scan with kill pulses, saturating score, fire sfx.
// Ports: clk, rst (async, active-high); tick_i movement strobe;
//   fire_valid_i/fire_ready_o + fire_x/y_i, fire_dx/dy_i spawn handshake;
//   enemy_x/y_i, enemy_active_i flattened enemy table (sampled live);
//   slot_active_o, slot_x/y_o bullet state; kill_valid_o/kill_idx_o kill pulse;
//   score_o saturating hits; fire_snd_o fire pulse; tick_overrun_o dropped tick.
// Option: define PROJ_POOL_LIFETIME_EN to expire bullets after LIFETIME moves.
module projectile_pool #(
  parameter int N_SLOTS   = 4,
  parameter int N_ENEMIES = 10,
  parameter int COORD_W   = 10,
  parameter int VEL_W     = 6,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int MARGIN    = 5,
  parameter int BULLET_W  = 5,
  parameter int BULLET_H  = 10,
  parameter int ENEMY_SZ  = 20,
  parameter int SCORE_MAX = 99
`ifdef PROJ_POOL_LIFETIME_EN
  ,
  parameter int LIFETIME  = 64
`endif
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           tick_i,
  input  logic                           fire_valid_i,
  output logic                           fire_ready_o,
  input  logic [COORD_W-1:0]             fire_x_i,
  input  logic [COORD_W-1:0]             fire_y_i,
  input  logic [VEL_W-1:0]               fire_dx_i,
  input  logic [VEL_W-1:0]               fire_dy_i,
  input  logic [N_ENEMIES*COORD_W-1:0]   enemy_x_i,
  input  logic [N_ENEMIES*COORD_W-1:0]   enemy_y_i,
  input  logic [N_ENEMIES-1:0]           enemy_active_i,
  output logic [N_SLOTS-1:0]             slot_active_o,
  output logic [N_SLOTS*COORD_W-1:0]     slot_x_o,
  output logic [N_SLOTS*COORD_W-1:0]     slot_y_o,
  output logic                           kill_valid_o,
  output logic [$clog2(N_ENEMIES)-1:0]   kill_idx_o,
  output logic [7:0]                     score_o,
  output logic                           fire_snd_o,
  output logic                           tick_overrun_o
);

  localparam int SW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam int EW = $clog2(N_ENEMIES);
  localparam logic [SW-1:0] SLAST = SW'(N_SLOTS - 1);
  localparam logic [EW-1:0] ELAST = EW'(N_ENEMIES - 1);
  localparam logic [COORD_W-1:0] XLO = COORD_W'(MARGIN);
  localparam logic [COORD_W-1:0] XHI = COORD_W'(SCREEN_W - MARGIN);
  localparam logic [COORD_W-1:0] YLO = COORD_W'(MARGIN);
  localparam logic [COORD_W-1:0] YHI = COORD_W'(SCREEN_H - MARGIN);
  localparam logic [COORD_W:0] BW  = (COORD_W + 1)'(BULLET_W);
  localparam logic [COORD_W:0] BH  = (COORD_W + 1)'(BULLET_H);
  localparam logic [COORD_W:0] ESZ = (COORD_W + 1)'(ENEMY_SZ);
  localparam logic [7:0] SMAX = 8'(SCORE_MAX);

  typedef enum logic [1:0] {IDLE, MOVE, SCAN} state_e;

  state_e               state_q, state_d;
  logic [N_SLOTS-1:0]   act_q, act_d;
  logic [COORD_W-1:0]   x_q [N_SLOTS];
  logic [COORD_W-1:0]   x_d [N_SLOTS];
  logic [COORD_W-1:0]   y_q [N_SLOTS];
  logic [COORD_W-1:0]   y_d [N_SLOTS];
  logic [VEL_W-1:0]     dx_q [N_SLOTS];
  logic [VEL_W-1:0]     dx_d [N_SLOTS];
  logic [VEL_W-1:0]     dy_q [N_SLOTS];
  logic [VEL_W-1:0]     dy_d [N_SLOTS];
  logic                 pend_q, pend_d;
  logic [SW-1:0]        s_q, s_d;
  logic [EW-1:0]        e_q, e_d;
  logic [N_ENEMIES-1:0] mask_q, mask_d;
  logic [7:0]           score_q, score_d;
  logic                 kv_q, kv_d;
  logic [EW-1:0]        ki_q, ki_d;
  logic                 snd_q, snd_d;
  logic                 ovr_q, ovr_d;

`ifdef PROJ_POOL_LIFETIME_EN
  localparam int LW = $clog2(LIFETIME + 1);
  logic [LW-1:0] life_q [N_SLOTS];
  logic [LW-1:0] life_d [N_SLOTS];
`endif

  logic                 fire_ready;
  logic [SW-1:0]        free_idx;
  logic [N_SLOTS-1:0]   keep_w;
  logic [COORD_W:0]     bx, by, ex, ey;
  logic                 hit;

  function automatic logic [COORD_W-1:0] sext(input logic [VEL_W-1:0] v);
    return {{(COORD_W - VEL_W){v[VEL_W-1]}}, v};
  endfunction

  assign fire_ready = (state_q == IDLE) && !(&act_q);

  always_comb begin
    free_idx = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!act_q[i]) free_idx = SW'(i);
    end
  end

  // A slot survives MOVE only while inside the live region
  always_comb begin
    for (int i = 0; i < N_SLOTS; i++) begin
`ifdef PROJ_POOL_LIFETIME_EN
      keep_w[i] = x_q[i] >= XLO && x_q[i] <= XHI &&
                  y_q[i] >= YLO && y_q[i] <= YHI &&
                  life_q[i] != '0;
`else
      keep_w[i] = x_q[i] >= XLO && x_q[i] <= XHI &&
                  y_q[i] >= YLO && y_q[i] <= YHI;
`endif
    end
  end

  // One extra bit so box edges near the screen limit cannot wrap
  assign bx = {1'b0, x_q[s_q]};
  assign by = {1'b0, y_q[s_q]};
  assign ex = {1'b0, enemy_x_i[e_q*COORD_W +: COORD_W]};
  assign ey = {1'b0, enemy_y_i[e_q*COORD_W +: COORD_W]};

  assign hit = (state_q == SCAN) && act_q[s_q] &&
               enemy_active_i[e_q] && !mask_q[e_q] &&
               (bx + BW >= ex) && (bx < ex + ESZ) &&
               (by + BH >= ey) && (by < ey + ESZ);

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    pend_d  = pend_q;
    s_d     = s_q;
    e_d     = e_q;
    mask_d  = mask_q;
    score_d = score_q;
    kv_d    = 1'b0;
    ki_d    = ki_q;
    snd_d   = 1'b0;
    ovr_d   = 1'b0;
`ifdef PROJ_POOL_LIFETIME_EN
    life_d  = life_q;
`endif
    unique case (state_q)
      IDLE: begin
        // zero velocity is consumed without taking a slot
        if (fire_valid_i && fire_ready &&
            (fire_dx_i != '0 || fire_dy_i != '0)) begin
          act_d[free_idx] = 1'b1;
          x_d[free_idx]   = fire_x_i;
          y_d[free_idx]   = fire_y_i;
          dx_d[free_idx]  = fire_dx_i;
          dy_d[free_idx]  = fire_dy_i;
          snd_d           = 1'b1;
`ifdef PROJ_POOL_LIFETIME_EN
          life_d[free_idx] = LW'(LIFETIME);
`endif
        end
        if (tick_i || pend_q) begin
          state_d = MOVE;
          pend_d  = 1'b0;
        end
      end
      MOVE: begin
        for (int i = 0; i < N_SLOTS; i++) begin
          if (act_q[i]) begin
            if (keep_w[i]) begin
              x_d[i] = x_q[i] + sext(dx_q[i]);
              y_d[i] = y_q[i] + sext(dy_q[i]);
`ifdef PROJ_POOL_LIFETIME_EN
              life_d[i] = life_q[i] - 1'b1;
`endif
            end else begin
              act_d[i] = 1'b0;
            end
          end
        end
        mask_d  = '0;
        s_d     = '0;
        e_d     = '0;
        state_d = SCAN;
      end
      SCAN: begin
        if (hit) begin
          act_d[s_q]  = 1'b0;
          mask_d[e_q] = 1'b1;
          kv_d        = 1'b1;
          ki_d        = e_q;
          if (score_q != SMAX) score_d = score_q + 8'd1;
          // a dead bullet has nothing left to hit
          s_d = s_q + 1'b1;
          e_d = '0;
          if (s_q == SLAST) state_d = IDLE;
        end else if (e_q == ELAST) begin
          s_d = s_q + 1'b1;
          e_d = '0;
          if (s_q == SLAST) state_d = IDLE;
        end else begin
          e_d = e_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // only one deferred tick is held; further ones are dropped
    if (state_q != IDLE && tick_i) begin
      if (pend_q) ovr_d = 1'b1;
      else        pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      act_q   <= '0;
      for (int i = 0; i < N_SLOTS; i++) begin
        x_q[i]  <= '0;
        y_q[i]  <= '0;
        dx_q[i] <= '0;
        dy_q[i] <= '0;
`ifdef PROJ_POOL_LIFETIME_EN
        life_q[i] <= '0;
`endif
      end
      pend_q  <= 1'b0;
      s_q     <= '0;
      e_q     <= '0;
      mask_q  <= '0;
      score_q <= '0;
      kv_q    <= 1'b0;
      ki_q    <= '0;
      snd_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
`ifdef PROJ_POOL_LIFETIME_EN
      life_q  <= life_d;
`endif
      pend_q  <= pend_d;
      s_q     <= s_d;
      e_q     <= e_d;
      mask_q  <= mask_d;
      score_q <= score_d;
      kv_q    <= kv_d;
      ki_q    <= ki_d;
      snd_q   <= snd_d;
      ovr_q   <= ovr_d;
    end
  end

  assign fire_ready_o   = fire_ready;
  assign slot_active_o  = act_q;
  assign kill_valid_o   = kv_q;
  assign kill_idx_o     = ki_q;
  assign score_o        = score_q;
  assign fire_snd_o     = snd_q;
  assign tick_overrun_o = ovr_q;

  for (genvar g = 0; g < N_SLOTS; g++) begin : g_out
    assign slot_x_o[g*COORD_W +: COORD_W] = x_q[g];
    assign slot_y_o[g*COORD_W +: COORD_W] = y_q[g];
  end

endmodule

// File: tb/tb_projectile_pool.sv
// tb_projectile_pool: vector table, directed corner sequences and
// randomized rounds against a transaction-level model of the pool.
module tb_projectile_pool;
  localparam int NS = 4;
  localparam int NE = 10;
  localparam int CW = 10;
  localparam int VW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic fv = 1'b0;
  logic fready;
  logic [CW-1:0] fx = '0, fy = '0;
  logic [VW-1:0] fdx = '0, fdy = '0;
  logic [NE*CW-1:0] exv, eyv;
  logic [NE-1:0] ea = '0;
  logic [NS-1:0] sact;
  logic [NS*CW-1:0] sx, sy;
  logic kv;
  logic [3:0] kidx;
  logic [7:0] score;
  logic snd, ovr;

  int ex[NE], ey[NE];
  int checks = 0, failures = 0;
  int kq[$];
  int ovr_cnt = 0;

  bit m_act[NS];
  int m_x[NS], m_y[NS], m_dx[NS], m_dy[NS], m_life[NS];
  int m_score;
  int ekq[$];

  always #5 clk = ~clk;

  always_comb begin
    for (int e = 0; e < NE; e++) begin
      exv[e*CW +: CW] = CW'(ex[e]);
      eyv[e*CW +: CW] = CW'(ey[e]);
    end
  end

  projectile_pool dut (
    .clk(clk), .rst(rst), .tick_i(tick),
    .fire_valid_i(fv), .fire_ready_o(fready),
    .fire_x_i(fx), .fire_y_i(fy),
    .fire_dx_i(fdx), .fire_dy_i(fdy),
    .enemy_x_i(exv), .enemy_y_i(eyv),
    .enemy_active_i(ea),
    .slot_active_o(sact), .slot_x_o(sx), .slot_y_o(sy),
    .kill_valid_o(kv), .kill_idx_o(kidx),
    .score_o(score), .fire_snd_o(snd),
    .tick_overrun_o(ovr)
  );

  always @(posedge clk) begin
    #1;
    if (kv) kq.push_back(int'(kidx));
    if (ovr) ovr_cnt++;
  end

  function automatic void chk(string n, int a, int e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < NS; i++) begin
      m_act[i] = 0; m_x[i] = 0; m_y[i] = 0;
      m_dx[i] = 0; m_dy[i] = 0; m_life[i] = 0;
    end
    m_score = 0;
    ekq.delete();
  endfunction

  function automatic int m_free();
    for (int i = 0; i < NS; i++) if (!m_act[i]) return i;
    return -1;
  endfunction

  function automatic void m_fire(int x, int y, int dx, int dy);
    int f = m_free();
    if (f >= 0 && (dx != 0 || dy != 0)) begin
      m_act[f] = 1;
      m_x[f] = x & 1023; m_y[f] = y & 1023;
      m_dx[f] = dx; m_dy[f] = dy;
      m_life[f] = 64;
    end
  endfunction

  function automatic void m_tick();
    bit [NE-1:0] mask = '0;
    for (int s = 0; s < NS; s++) begin
      if (m_act[s]) begin
        bit live = m_x[s] >= 5 && m_x[s] <= 635 &&
                   m_y[s] >= 5 && m_y[s] <= 475;
`ifdef PROJ_POOL_LIFETIME_EN
        live = live && m_life[s] > 0;
        if (live) m_life[s]--;
`endif
        if (live) begin
          m_x[s] = (m_x[s] + m_dx[s]) & 1023;
          m_y[s] = (m_y[s] + m_dy[s]) & 1023;
        end else m_act[s] = 0;
      end
    end
    for (int s = 0; s < NS; s++) begin
      if (m_act[s]) begin
        for (int e = 0; e < NE; e++) begin
          if (ea[e] && !mask[e] &&
              m_x[s] + 5 >= ex[e] && m_x[s] < ex[e] + 20 &&
              m_y[s] + 10 >= ey[e] && m_y[s] < ey[e] + 20) begin
            m_act[s] = 0;
            mask[e] = 1;
            if (m_score < 99) m_score++;
            ekq.push_back(e);
            break;
          end
        end
      end
    end
  endfunction

  task automatic do_reset();
    rst = 1; tick = 0; fv = 0; ea = '0;
    for (int e = 0; e < NE; e++) begin ex[e] = 0; ey[e] = 0; end
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    m_reset();
  endtask

  task automatic fire(int x, int y, int dx, int dy, output bit s);
    bit ok;
    fx = CW'(x & 1023); fy = CW'(y & 1023);
    fdx = VW'(dx); fdy = VW'(dy);
    fv = 1;
    ok = m_free() >= 0;
    chk("fire_ready", int'(fready), int'(ok));
    @(negedge clk);
    fv = 0;
    s = snd;
    chk("fire_snd", int'(snd), int'(ok && (dx != 0 || dy != 0)));
    m_fire(x, y, dx, dy);
  endtask

  task automatic tick_wait(output int nk, output int k0);
    int kb = kq.size();
    tick = 1;
    @(negedge clk);
    tick = 0;
    repeat (50) @(negedge clk);
    ekq.delete();
    m_tick();
    nk = kq.size() - kb;
    k0 = (nk > 0) ? kq[kb] : -1;
    chk("kill_cnt", nk, ekq.size());
    for (int i = 0; i < nk && i < ekq.size(); i++)
      chk("kill_idx", kq[kb+i], ekq[i]);
  endtask

  task automatic compare_state(string t);
    logic [NS-1:0] ma;
    for (int i = 0; i < NS; i++) ma[i] = m_act[i];
    chk({t, "_act"}, int'(sact), int'(ma));
    for (int i = 0; i < NS; i++) begin
      chk({t, "_x"}, int'(sx[i*CW +: CW]), m_x[i]);
      chk({t, "_y"}, int'(sy[i*CW +: CW]), m_y[i]);
    end
    chk({t, "_score"}, int'(score), m_score);
  endtask

  typedef struct {
    int fx, fy, dx, dy, nt;
    int ex, ey, ea, es;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[7];
    bit sb;
    int nk, k0, o0, kb;
    bit got;

    vt[0] = '{100, 100,  2,  -1, 3,  106,  97, 1, 1};
    vt[1] = '{636,  50,  1,   0, 1,  636,  50, 0, 1};
    vt[2] = '{ 10,  10, -3,   0, 2,    4,  10, 1, 1};
    vt[3] = '{  6,   6,  0,  -2, 2,    6,   4, 0, 1};
    vt[4] = '{  5,   5, -8,   0, 2, 1021,   5, 0, 1};
    vt[5] = '{300, 200,  0,   0, 1,    0,   0, 0, 0};
    vt[6] = '{635, 475, 31, -32, 1,  666, 443, 1, 1};

    for (int e = 0; e < NE; e++) begin ex[e] = 0; ey[e] = 0; end
    @(negedge clk);
    chk("rst_act", int'(sact), 0);
    chk("rst_x", int'(sx), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_kv", int'(kv), 0);
    chk("rst_snd", int'(snd), 0);
    chk("rst_ovr", int'(ovr), 0);
    chk("rst_ready", int'(fready), 1);

    // vector table: single bullet, no enemies
    for (int i = 0; i < 7; i++) begin
      do_reset();
      fire(vt[i].fx, vt[i].fy, vt[i].dx, vt[i].dy, sb);
      chk("vec_snd", int'(sb), vt[i].es);
      for (int t = 0; t < vt[i].nt; t++) tick_wait(nk, k0);
      chk("vec_x", int'(sx[CW-1:0]), vt[i].ex);
      chk("vec_y", int'(sy[CW-1:0]), vt[i].ey);
      chk("vec_act", int'(sact), vt[i].ea);
    end

    // full pool, held fifth fire waits for a freed slot
    do_reset();
    fire(636, 50, 1, 0, sb);
    fire(100, 100, 1, 0, sb);
    fire(200, 100, 1, 0, sb);
    fire(300, 100, 1, 0, sb);
    chk("full_act", int'(sact), 15);
    chk("full_ready", int'(fready), 0);
    fx = 400; fy = 300; fdx = 1; fdy = 1;
    fv = 1; tick = 1;
    @(negedge clk);
    tick = 0;
    got = 0;
    for (int c = 0; c < 100 && !got; c++) begin
      if (fready) got = 1;
      @(negedge clk);
    end
    fv = 0;
    chk("fire5_accept", int'(got), 1);
    chk("fire5_snd", int'(snd), 1);
    m_tick();
    m_fire(400, 300, 1, 1);
    compare_state("fire5");

    // two bullets on one enemy: single kill
    do_reset();
    ex[3] = 200; ey[3] = 200; ea = 10'b0000001000;
    fire(205, 205, 1, 0, sb);
    fire(210, 210, 1, 0, sb);
    tick_wait(nk, k0);
    chk("dup_nk", nk, 1);
    chk("dup_idx", k0, 3);
    chk("dup_score", int'(score), 1);
    chk("dup_act", int'(sact), 2);

    // score saturation plus bounds kill ahead of the scan
    do_reset();
    for (int k = 0; k < 4; k++) begin
      ex[k] = 50 + 100 * k; ey[k] = 100;
    end
    ex[4] = 620; ey[4] = 100;
    ea = 10'b0000011111;
    for (int r = 0; r < 24; r++) begin
      for (int k = 0; k < 4; k++) fire(52 + 100 * k, 102, 1, 0, sb);
      tick_wait(nk, k0);
      compare_state("sat");
    end
    chk("sat_96", int'(score), 96);
    for (int k = 0; k < 2; k++) fire(52 + 100 * k, 102, 1, 0, sb);
    tick_wait(nk, k0);
    chk("sat_98", int'(score), 98);
    for (int k = 0; k < 3; k++) fire(52 + 100 * k, 102, 1, 0, sb);
    fire(636, 100, 1, 0, sb);
    tick_wait(nk, k0);
    chk("sat_nk", nk, 3);
    chk("sat_99", int'(score), 99);
    chk("sat_act", int'(sact), 0);
    compare_state("sat_end");

    // pending tick and overrun
    do_reset();
    fire(100, 100, 1, 0, sb);
    o0 = ovr_cnt;
    tick = 1; @(negedge clk); tick = 0;
    repeat (5) @(negedge clk);
    tick = 1; @(negedge clk); tick = 0;
    @(negedge clk);
    tick = 1; @(negedge clk); tick = 0;
    repeat (120) @(negedge clk);
    chk("ovr_cnt", ovr_cnt - o0, 1);
    chk("pend_x", int'(sx[CW-1:0]), 102);
    m_tick(); m_tick();
    compare_state("pend");

    // reset in the middle of a scan
    do_reset();
    ex[9] = 100; ey[9] = 100; ea = 10'b1000000000;
    fire(100, 100, 1, 0, sb);
    kb = kq.size();
    tick = 1; @(negedge clk); tick = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    #1;
    chk("mrst_act", int'(sact), 0);
    chk("mrst_x", int'(sx), 0);
    chk("mrst_kv", int'(kv), 0);
    chk("mrst_score", int'(score), 0);
    chk("mrst_ready", int'(fready), 1);
    @(negedge clk);
    rst = 0;
    repeat (60) @(negedge clk);
    chk("mrst_nokill", kq.size() - kb, 0);
    chk("mrst_ready2", int'(fready), 1);
    m_reset();
    compare_state("mrst");

    // randomized rounds against the model
    do_reset();
    for (int r = 0; r < 30; r++) begin
      for (int e = 0; e < NE; e++) begin
        ex[e] = $urandom_range(0, 620);
        ey[e] = $urandom_range(0, 460);
      end
      ea = NE'($urandom);
      for (int f = 0, n = $urandom_range(0, 4); f < n; f++) begin
        int t = $urandom_range(0, NE - 1);
        int dx = $urandom_range(0, 63) - 32;
        int dy = $urandom_range(0, 63) - 32;
        if ($urandom_range(0, 7) == 0) begin dx = 0; dy = 0; end
        fire(ex[t] + $urandom_range(0, 30) - 10,
             ey[t] + $urandom_range(0, 30) - 10, dx, dy, sb);
      end
      tick_wait(nk, k0);
      compare_state("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
